// File: rtl/regfile_multiport_if.sv
// Bus between decode/writeback and the register file: one write port,
// NREAD packed read ports and the clear-complete flag.
interface regfile_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NREAD = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic                  ready;
  logic                  w_enable;
  logic [AW-1:0]         w_address;
  logic [XLEN-1:0]       w_data;
  logic [NREAD-1:0]      r_enable;
  logic [NREAD*AW-1:0]   r_address;
  logic [NREAD*XLEN-1:0] r_out;

  // Pipeline side: issues reads and writes, consumes read data.
  modport master (
    input  ready,
    input  r_out,
    output w_enable,
    output w_address,
    output w_data,
    output r_enable,
    output r_address
  );

  // Register file side.
  modport slave (
    output ready,
    output r_out,
    input  w_enable,
    input  w_address,
    input  w_data,
    input  r_enable,
    input  r_address
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with registered reads and a post-reset clear
// sequencer that zeroes one entry per cycle so the array stays RAM-mappable.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first forwarding of
// same-cycle writes to reads; undefined gives read-first behaviour.
module regfile_multiport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);
  localparam int unsigned   AW      = $clog2(NREGS);
  localparam logic [AW-1:0] CntLast = AW'(NREGS - 1);
  localparam bit            ZeroHw  = (ZERO_REG != 0);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q;
  logic [AW-1:0]         cnt_q;
  logic                  ready_q;
  logic [NREAD*XLEN-1:0] r_out_q;
  logic [NREAD*XLEN-1:0] r_out_d;

  logic [XLEN-1:0]       mem [NREGS];

  logic                  w_accept;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [XLEN-1:0]       mem_wdata;

  assign bus.ready = ready_q;
  assign bus.r_out = r_out_q;

  // Accepted writes: RUN only, and never into a hardwired zero register.
  always_comb begin
    w_accept = (state_q == StRun) && bus.w_enable &&
               !(ZeroHw && (bus.w_address == '0));
  end

  // Single array write port shared by the clear sequencer and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.w_address;
    mem_wdata = bus.w_data;
    if (rst_n) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end else if (w_accept) begin
        mem_we = 1'b1;
      end
    end
  end

  // Next read data per port; disabled ports keep their last value.
  always_comb begin
    r_out_d = r_out_q;
    for (int unsigned i = 0; i < NREAD; i++) begin
      if (bus.r_enable[i]) begin
        if (ZeroHw && (bus.r_address[i*AW +: AW] == '0)) begin
          r_out_d[i*XLEN +: XLEN] = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (w_accept && (bus.r_address[i*AW +: AW] == bus.w_address)) begin
          r_out_d[i*XLEN +: XLEN] = bus.w_data;
`endif
        end else begin
          r_out_d[i*XLEN +: XLEN] = mem[bus.r_address[i*AW +: AW]];
        end
      end
    end
  end

  // Array storage, no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Clear/run sequencer with registered ready and read outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      r_out_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          r_out_q <= '0;
          if (cnt_q == CntLast) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          r_out_q <= r_out_d;
        end
        default: begin
          state_q <= StClear;
          cnt_q   <= '0;
          ready_q <= 1'b0;
          r_out_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: two register files (ZERO_REG=1 and ZERO_REG=0) share one
// stimulus stream; checks are immediate assertions against hand-computed values.
module tb_regfile_multiport;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NREAD = 2;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_z ();
  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_n ();

  assign bus_n.w_enable  = bus_z.w_enable;
  assign bus_n.w_address = bus_z.w_address;
  assign bus_n.w_data    = bus_z.w_data;
  assign bus_n.r_enable  = bus_z.r_enable;
  assign bus_n.r_address = bus_z.r_address;

  regfile_multiport #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(1)
  ) dut_z (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_z)
  );

  regfile_multiport #(
    .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .ZERO_REG(0)
  ) dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_z.w_enable  = 1'b1;
    bus_z.w_address = a;
    bus_z.w_data    = d;
    step();
    bus_z.w_enable  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus_z.r_enable  = 2'b11;
    bus_z.r_address = {a1, a0};
    step();
  endtask

  logic [31:0] exp_byp;

  initial begin
    rst_n           = 1'b0;
    bus_z.w_enable  = 1'b0;
    bus_z.w_address = '0;
    bus_z.w_data    = '0;
    bus_z.r_enable  = '0;
    bus_z.r_address = '0;
    step();
    step();
    check("reset_ready", {31'd0, bus_z.ready}, 32'd0);
    check("reset_rout0", bus_z.r_out[31:0], 32'd0);
    check("reset_rout1", bus_z.r_out[63:32], 32'd0);

    // Clear sequence: ready only after the 32nd edge.
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      check("clear_ready", {31'd0, bus_z.ready}, (e == 32) ? 32'd1 : 32'd0);
    end

    for (int a = 0; a < 32; a += 2) begin
      rd(5'(a), 5'(a + 1));
      check("init_z_p0", bus_z.r_out[31:0], 32'd0);
      check("init_z_p1", bus_z.r_out[63:32], 32'd0);
      check("init_n_p0", bus_n.r_out[31:0], 32'd0);
      check("init_n_p1", bus_n.r_out[63:32], 32'd0);
    end

    // Write then read on both ports.
    bus_z.r_enable = 2'b00;
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd5);
    check("x5_p0", bus_z.r_out[31:0], 32'hDEAD_BEEF);
    check("x5_p1", bus_z.r_out[63:32], 32'hDEAD_BEEF);

    // Zero register behaviour.
    bus_z.r_enable = 2'b00;
    wr(5'd0, 32'h1234_5678);
    rd(5'd0, 5'd0);
    check("x0_zero_reg", bus_z.r_out[31:0], 32'd0);
    check("x0_plain_reg", bus_n.r_out[31:0], 32'h1234_5678);

    // Same-cycle write and read of x7.
    bus_z.r_enable = 2'b00;
    wr(5'd7, 32'h0000_0001);
    bus_z.r_enable  = 2'b01;
    bus_z.r_address = {5'd0, 5'd7};
    bus_z.w_enable  = 1'b1;
    bus_z.w_address = 5'd7;
    bus_z.w_data    = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hA5A5_A5A5;
`else
    exp_byp = 32'h0000_0001;
`endif
    step();
    bus_z.w_enable = 1'b0;
    check("x7_same_cycle", bus_z.r_out[31:0], exp_byp);
    step();
    check("x7_next_read", bus_z.r_out[31:0], 32'hA5A5_A5A5);

    // Disabled port 1 holds while its address moves.
    rd(5'd7, 5'd5);
    check("hold_load", bus_z.r_out[63:32], 32'hDEAD_BEEF);
    bus_z.r_enable = 2'b01;
    for (int k = 0; k < 3; k++) begin
      bus_z.r_address = {5'(7 + k), 5'd7};
      step();
      check("hold_p1", bus_z.r_out[63:32], 32'hDEAD_BEEF);
    end

    // Fill x1..x31 with nonzero values.
    bus_z.r_enable = 2'b00;
    for (int a = 1; a < 32; a++) begin
      wr(5'(a), 32'h1000_0000 + 32'(a));
    end
    rd(5'd1, 5'd31);
    check("fill_x1", bus_z.r_out[31:0], 32'h1000_0001);
    check("fill_x31", bus_z.r_out[63:32], 32'h1000_001F);

    // Reset in RUN, then again mid-clear, with writes attempted throughout.
    bus_z.w_enable  = 1'b1;
    bus_z.w_address = 5'd1;
    bus_z.w_data    = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    step();
    check("run_rst_ready", {31'd0, bus_z.ready}, 32'd0);
    check("run_rst_rout", bus_z.r_out[31:0], 32'd0);
    rst_n = 1'b1;
    for (int e = 0; e < 10; e++) step();
    check("mid_clear_ready", {31'd0, bus_z.ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      step();
      check("reclear_ready", {31'd0, bus_z.ready}, (e == 32) ? 32'd1 : 32'd0);
      if (e == 16) check("clear_rout", bus_z.r_out[31:0], 32'd0);
    end
    bus_z.w_enable = 1'b0;

    for (int a = 0; a < 32; a += 2) begin
      rd(5'(a), 5'(a + 1));
      check("post_z_p0", bus_z.r_out[31:0], 32'd0);
      check("post_z_p1", bus_z.r_out[63:32], 32'd0);
      check("post_n_p0", bus_n.r_out[31:0], 32'd0);
      check("post_n_p1", bus_n.r_out[63:32], 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised general-purpose register file for the CPU core: configurable data width, register count and number of read ports, with one write port. Read ports are registered (one-cycle latency, read enables hold the last value), register 0 optionally hardwired to zero. After reset a built-in clear sequencer zeroes every entry one per cycle, so the array still maps onto block RAM. Sits between decode (read addresses) and writeback (write port).

## Interface
- `XLEN`, 32: data width in bits, ≥1.
- `NREGS`, 32: number of registers, power of two, ≥2; `AW = $clog2(NREGS)`.
- `NREAD`, 2: number of read ports, ≥1.
- `ZERO_REG`, 1: 1 = register 0 reads zero and ignores writes; 0 = ordinary register.

- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `ready` out 1: high when the clear sequence has completed.
- `w_enable` in 1: write strobe.
- `w_address` in AW: write register index.
- `w_data` in XLEN: write data.
- `r_enable` in NREAD: per-port read enable, bit i → port i.
- `r_address` in NREAD*AW: packed read indices, port i at `[i*AW +: AW]`.
- `r_out` out NREAD*XLEN: packed registered read data, port i at `[i*XLEN +: XLEN]`.

## Operation
- States: CLEAR, RUN. A clear counter `cnt` of AW bits indexes the array.
- `rst_n` low at an edge: state←CLEAR, `cnt`←0, `ready`←0, all `r_out`←0. The array is not written on that edge.
- CLEAR, `rst_n` high: writes 0 to `mem[cnt]`, then `cnt`←`cnt`+1. When `cnt`==NREGS−1, the same edge moves the state to RUN and sets `ready`←1. All `w_enable` is ignored in CLEAR. Each `r_out` port loads 0 on every edge.
- RUN, write: if `w_enable`, then `mem[w_address]`←`w_data`. The exception is `w_address`==0 with ZERO_REG=1, which is dropped.
- RUN, read port i:
  - If `r_enable[i]`, `r_out[i]` loads the array at `r_address[i]`. It loads 0 when the address is 0 and ZERO_REG=1.
  - If not `r_enable[i]`, `r_out[i]` holds its value.
- Read data for a same-cycle write to the same address is set by `REGFILE_BYPASS_EN` (see Configuration).
- Multiple read ports may read the same address. Each port is independent.
- `rst_n` low mid-CLEAR or in RUN restarts the full sequence. The previous contents are lost.
- No arithmetic on data. `cnt` never wraps in use because it stops at NREGS−1.

## Timing
- Reset values: `ready`=0 and `r_out`=0 on the edge where `rst_n` is sampled low.
- `ready` rises on the NREGS-th rising edge with `rst_n` high after reset. For example, with NREGS=32 reset is released before edge 1 and `ready` is high after edge 32.
- Read latency is 1 cycle: an address presented before edge k appears on `r_out` after edge k.
- A write presented before edge k is visible to a read issued before edge k+1, in every configuration.
- The first accepted write is in the cycle where `ready` is already 1.

## Configuration
- `REGFILE_BYPASS_EN` defined: when a RUN-state read uses the same address as an accepted write in the same cycle, `r_out` loads `w_data`. This is write-first, and the forwarding is suppressed for the zero register when ZERO_REG=1.
- Not defined: the read returns the old array contents (read-first). `w_data` then appears one cycle later.
- The macro has no effect in CLEAR.

## Test plan
- Reset release with NREGS=32 → `ready`=0 for 31 edges and =1 after edge 32. A read of every address then returns 0.
- Write 0xDEADBEEF to x5 in RUN, then read x5 on port 0 and port 1 the next cycle → both ports show 0xDEADBEEF after one edge.
- With ZERO_REG=1, write 0x12345678 to x0 and then read x0 → 0. Repeat with ZERO_REG=0 → 0x12345678.
- Write 0xA5A5A5A5 to x7 while port 0 reads x7 in the same cycle, with x7 previously 0x1:
  - With `REGFILE_BYPASS_EN` → `r_out[0]`=0xA5A5A5A5.
  - Without it → 0x1, then 0xA5A5A5A5 on the next read.
- Hold `r_enable[1]`=0 for 3 cycles while changing `r_address[1]` → `r_out[1]` is unchanged.
- Fill x1..x31 with nonzero values, pulse `rst_n` low for one cycle mid-clear and again in RUN, and issue writes while `ready`=0:
  - Writes are ignored.
  - `ready` returns after 32 edges.
  - All registers read 0.
